// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared select codes and FSM encoding for the cl test path
package cl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cl_ref_model.sv
// rtl/cl_ref_model.sv - golden 1-bit logic cell, combinational
module cl_ref_model
  import cl_pkg::*;
(
  input  logic [1:0] s,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (s)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NOT:  expected = ~a;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/cl_resp_checker.sv
// rtl/cl_resp_checker.sv - BIST response checker for the 1-bit logic cell
// Optional per-select error counters on err_by_op when CL_CHK_PEROP_EN is defined.
module cl_resp_checker
  import cl_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:0]       in_s,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_out,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [4:0]       first_fail_vec
`ifdef CL_CHK_PEROP_EN
  ,
  output logic [4*CNT_W-1:0] err_by_op
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [4:0]       ffv_q, ffv_d;
`ifdef CL_CHK_PEROP_EN
  logic [3:0][CNT_W-1:0] op_err_q, op_err_d;
`endif

  logic expected;
  logic accept;
  logic mismatch;

  cl_ref_model u_ref (
    .s        (in_s),
    .a        (in_a),
    .b        (in_b),
    .expected (expected)
  );

  // A start in the same cycle as a vector wins; the vector is dropped.
  assign accept   = in_valid & (state_q == RUN) & ~start;
  assign mismatch = expected ^ in_out;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    ffi_d       = ffi_q;
    ffv_d       = ffv_q;
`ifdef CL_CHK_PEROP_EN
    op_err_d    = op_err_q;
`endif
    if (start) begin
      state_d     = RUN;
      in_ready_d  = 1'b1;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      err_count_d = '0;
      vec_count_d = '0;
      ffi_d       = '0;
      ffv_d       = '0;
`ifdef CL_CHK_PEROP_EN
      op_err_d    = '0;
`endif
    end else if (accept) begin
      vec_count_d = vec_count_q + 1'b1;
      if (mismatch) begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
        // err_count only ever grows within a run, so zero means no capture yet.
        if (err_count_q == '0) begin
          ffi_d = vec_count_q;
          ffv_d = {in_s, in_a, in_b, in_out};
        end
`ifdef CL_CHK_PEROP_EN
        if (op_err_q[in_s] != CNT_MAX) op_err_d[in_s] = op_err_q[in_s] + 1'b1;
`endif
      end
      if (vec_count_q == LAST_IDX) begin
        state_d    = DONE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        pass_d     = (err_count_d == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      vec_count_q <= '0;
      ffi_q       <= '0;
      ffv_q       <= '0;
`ifdef CL_CHK_PEROP_EN
      op_err_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      ffi_q       <= ffi_d;
      ffv_q       <= ffv_d;
`ifdef CL_CHK_PEROP_EN
      op_err_q    <= op_err_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign vec_count      = vec_count_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vec = ffv_q;
`ifdef CL_CHK_PEROP_EN
  assign err_by_op      = op_err_q;
`endif

endmodule

// File: tb/tb_cl_resp_checker.sv
// tb/tb_cl_resp_checker.sv - self-checking bench for cl_resp_checker
module tb_cl_resp_checker;

  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic [1:0]       in_s;
  logic             in_a;
  logic             in_b;
  logic             in_out;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic [4:0]       first_fail_vec;
`ifdef CL_CHK_PEROP_EN
  logic [4*CNT_W-1:0] err_by_op;
`endif

  cl_resp_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_s           (in_s),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_out         (in_out),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .vec_count      (vec_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_vec (first_fail_vec)
`ifdef CL_CHK_PEROP_EN
    ,
    .err_by_op      (err_by_op)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  bit         m_run;
  bit         m_done;
  int         m_vec;
  int         m_err;
  int         m_ffi;
  logic [4:0] m_ffv;
  int         m_op[4];

  function automatic bit golden(input int s, input bit a, input bit b);
    case (s)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_vec = 0;
    m_err = 0;
    m_ffi = 0;
    m_ffv = '0;
    for (int k = 0; k < 4; k++) m_op[k] = 0;
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    model_clear();
  endtask

  task automatic model_step(input bit st, input bit v, input logic [1:0] s,
                            input bit a, input bit b, input bit o);
    if (st) begin
      m_run  = 1'b1;
      m_done = 1'b0;
      model_clear();
    end else if (m_run && v) begin
      if (golden(int'(s), a, b) != o) begin
        if (m_err == 0) begin
          m_ffi = m_vec;
          m_ffv = {s, a, b, o};
        end
        if (m_err < CMAX) m_err++;
        if (m_op[s] < CMAX) m_op[s]++;
      end
      m_vec++;
      if (m_vec == NUM_VEC) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking && !reset) begin
      chk("in_ready", in_ready, m_run);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_err == 0);
      chk("err_count", err_count, m_err);
      chk("vec_count", vec_count, m_vec);
      chk("first_fail_idx", first_fail_idx, m_ffi);
      chk("first_fail_vec", first_fail_vec, m_ffv);
`ifdef CL_CHK_PEROP_EN
      for (int k = 0; k < 4; k++)
        chk("err_by_op", err_by_op[k*CNT_W +: CNT_W], m_op[k]);
`endif
    end
  end

  task automatic cyc(input bit st, input bit v, input logic [1:0] s,
                     input bit a, input bit b, input bit o);
    start    = st;
    in_valid = v;
    in_s     = s;
    in_a     = a;
    in_b     = b;
    in_out   = o;
    @(posedge clk);
    model_step(st, v, s, a, b, o);
    #2;
  endtask

  task automatic sweep_vec(input int i, input bit flip);
    logic [1:0] s;
    bit a, b;
    s = 2'(i >> 2);
    a = i[1];
    b = i[0];
    cyc(1'b0, 1'b1, s, a, b, golden(int'(s), a, b) ^ flip);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_s = 2'b00;
    in_a = 1'b0;
    in_b = 1'b0;
    in_out = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_counts", {err_count, vec_count, first_fail_idx, first_fail_vec}, 0);
    reset = 1'b0;
    checking = 1'b1;

    // Clean sweep; in_valid while IDLE first must be ignored.
    cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("idle_ignore_vec", vec_count, 0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_VEC; i++) sweep_vec(i, 1'b0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_vec", vec_count, 16);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_model_vec", m_vec, 16);
    sweep_vec(3, 1'b1);
    chk("done_ignore_vec", vec_count, 16);
    chk("done_ignore_err", err_count, 0);

    // Vector 5 wrong.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_VEC; i++) sweep_vec(i, i == 5);
    chk("t2_err", err_count, 1);
    chk("t2_pass", pass, 0);
    chk("t2_done", done, 1);
    chk("t2_ffi", first_fail_idx, 5);
    chk("t2_ffv", first_fail_vec, 5'b01010);
    chk("t2_model_ffv", m_ffv, 5'b01010);

    // Vectors 2 and 13 wrong.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t3_cleared", {err_count, vec_count, first_fail_idx, done}, 0);
    for (int i = 0; i < NUM_VEC; i++) sweep_vec(i, i == 2 || i == 13);
    chk("t3_err", err_count, 2);
    chk("t3_ffi", first_fail_idx, 2);
    chk("t3_ffv", first_fail_vec, 5'b00101);

    // Restart after 7 accepts with a vector presented alongside start.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) sweep_vec(i, i == 1);
    chk("t4_pre_vec", vec_count, 7);
    cyc(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
    chk("t4_restart_vec", vec_count, 0);
    chk("t4_restart_err", err_count, 0);
    for (int i = 0; i < NUM_VEC; i++) sweep_vec(i, 1'b0);
    chk("t4_pass", pass, 1);
    chk("t4_vec", vec_count, 16);

    // Asynchronous reset mid-run.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) sweep_vec(i, i == 4);
    reset = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", in_ready, 0);
    chk("t5_async_counts", {err_count, vec_count, first_fail_idx, first_fail_vec, done, pass}, 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) sweep_vec(i, 1'b1);
    chk("t5_post_vec", vec_count, 0);
    chk("t5_post_err", err_count, 0);

`ifdef CL_CHK_PEROP_EN
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_VEC; i++) sweep_vec(i, (i >> 2) == 3);
    chk("t6_op3", err_by_op[3*CNT_W +: CNT_W], 4);
    chk("t6_op012", err_by_op[3*CNT_W-1:0], 0);
    chk("t6_err", err_count, 4);
`endif

    // Randomised runs with gaps, bad vectors and occasional restarts.
    for (int run = 0; run < 25; run++) begin
      int budget;
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      budget = 0;
      while (!m_done && budget < 400) begin
        logic [1:0] s;
        bit a, b, v, flip, st;
        s    = 2'($urandom_range(0, 3));
        a    = 1'($urandom_range(0, 1));
        b    = 1'($urandom_range(0, 1));
        v    = ($urandom_range(0, 3) != 0);
        flip = ($urandom_range(0, 4) == 0);
        st   = ($urandom_range(0, 59) == 0);
        cyc(st, v, s, a, b, golden(int'(s), a, b) ^ flip);
        budget++;
      end
      chk("rand_run_finished", m_done, 1);
      for (int k = 0; k < 3; k++) begin
        logic [1:0] s;
        s = 2'($urandom_range(0, 3));
        cyc(1'b0, 1'($urandom_range(0, 1)), s, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cl_resp_checker.md
Name: cl_resp_checker

Overview:
- Response-analysis end of the 1-bit logic cell (cl) test path.
- Accepts a stream of applied vectors {s, a, b} together with the cell's observed output.
- Recomputes the expected result with a golden model and counts mismatches.
- Reports pass/fail after a fixed number of vectors; used as the on-chip BIST checker beside the 4-bit ALU.

Parameters:
- NUM_VEC, 16: vectors per run; the full sweep is 4 selects x 4 operand pairs.
- CNT_W, 8: width of the vector counter and the error counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle pulse; begins or restarts a run
- in_valid  input  1  a vector is present on in_s/in_a/in_b/in_out
- in_s  input  2  select code applied to the cell
- in_a  input  1  operand a applied
- in_b  input  1  operand b applied
- in_out  input  1  cell output observed for that vector
- in_ready  output  1  checker accepts a vector this cycle
- busy  output  1  run in progress
- done  output  1  run complete; held until the next start
- pass  output  1  valid when done; 1 when err_count == 0
- err_count  output  CNT_W  mismatches seen, saturating
- vec_count  output  CNT_W  vectors accepted this run
- first_fail_idx  output  CNT_W  index (0-based) of the first mismatching vector
- first_fail_vec  output  5  {s, a, b, out} of the first mismatch

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: all outputs 0; state is IDLE.
- Golden function:
  - s=00: a AND b
  - s=01: a OR b
  - s=10: a XOR b
  - s=11: NOT a
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=0, busy=0. start moves to RUN and clears the counters and first-fail registers.
  - RUN: in_ready=1, busy=1. A vector is accepted on in_valid & in_ready.
    - Each accept increments vec_count.
    - On a mismatch, err_count increments and saturates at 2^CNT_W-1.
    - If this is the first mismatch, vec_count (the pre-increment value) is captured into first_fail_idx and the vector into first_fail_vec.
  - RUN to DONE: taken on the edge that accepts vector NUM_VEC-1. done and pass are registered and visible the next cycle.
  - DONE: in_ready=0, done=1. pass = (err_count==0). Counters hold. start returns to RUN with counters cleared.
- Latency: counters and first-fail registers update one cycle after accept. pass and done rise together one cycle after the final accept.
- start while in RUN: restarts the run. Counters clear, and any vector presented in the same cycle is discarded, not counted.
- in_valid in IDLE or DONE: ignored, with no state change.
- No failure: first_fail_idx and first_fail_vec stay 0. Distinguish "no failure" from "failure at index 0" using err_count.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No partial result is retained.
- NUM_VEC must be between 1 and 2^CNT_W-1. vec_count never wraps inside a run.

Optional Feature:
- Macro: CL_CHK_PEROP_EN.
- When defined:
  - Adds output err_by_op [4*CNT_W-1:0], holding four saturating per-select mismatch counters; slice k corresponds to s=k.
  - These counters clear on start and on reset, and update in the same cycle as err_count.
- When undefined:
  - The port and the counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package cl_pkg holds:
  - the select-code constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11
  - the FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
- One combinational sub-module, cl_ref_model: inputs s, a, b; output expected. It is reused by later ALU checkers.

Test Plan:
- Reset, then start, then 16 correct vectors in sweep order (s, then a, then b ascending) -> done=1, pass=1, err_count=0, vec_count=16, in_ready=0.
- Same sweep but vector 5 (s=01, a=0, b=1) has out=0 -> err_count=1, pass=0, first_fail_idx=5, first_fail_vec=5'b01010.
- Vector 2 and vector 13 are wrong -> err_count=2, first_fail_idx=2 (the first capture is retained).
- After 7 accepts, pulse start with in_valid=1 -> vec_count=0 the next cycle and that vector is not counted; 16 further good vectors -> pass=1.
- Assert reset asynchronously mid-run after 9 vectors -> all outputs 0 within the reset cycle and the FSM is in IDLE; in_valid pulses afterwards are ignored until start.
- With CL_CHK_PEROP_EN defined: flip out on every s=11 vector -> err_by_op slice 3 = 4, the other slices 0, err_count=4.
